mel_frame_serializer: RTL and testbench
=======================================

Name: mel_frame_serializer

Overview:
- Consumes the 40-band, 16-bit parallel mel energy frame (dB) presented with a valid/ready handshake by the filter bank.
- Re-emits each frame as a serial coefficient stream for downstream logging, DCT or UART/DMA transport.
- Double-buffers two frames, so the producer is stalled only while both buffers hold undrained frames.
- Tags every beat with its band index, a last-of-frame flag and a wrapping frame number.

Parameters:
NUM_BANDS, 40, coefficients per frame; index width is 6 bits, sized for up to 64 bands
WIDTH, 16, bits per coefficient
FRAME_CNT_W, 8, width of frame sequence counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in  input  WIDTH x NUM_BANDS (unpacked array)  parallel frame, in[0] = lowest band
s_valid  input  1  frame on in is valid
s_ready  output  1  block can accept a frame this cycle
m_data  output  WIDTH  current coefficient
m_index  output  6  band index of m_data, 0..NUM_BANDS-1
m_frame  output  FRAME_CNT_W  sequence number of frame being emitted
m_last  output  1  high when m_index == NUM_BANDS-1
m_valid  output  1  m_data/m_index/m_frame/m_last valid
m_ready  input  1  downstream accepts beat

Behaviour:
- Reset is asynchronous, active-high, on clock clk. Registers cleared on reset:
  - full[1:0] = 0, wr_sel = 0, rd_sel = 0, idx = 0, frame_cnt = 0.
  - s_ready = 0 while reset is asserted.
  - Outputs: m_valid = 0, m_index = 0, m_frame = 0, m_last = 0, m_data = 0.
- Buffer contents are not reset.
- Storage: two banks buf[2][NUM_BANDS] of WIDTH bits, each with a full flag.
- Input side:
  - s_ready is registered and equals !full[wr_sel]. There is no combinational path from m_ready to s_ready.
  - On s_valid & s_ready: all NUM_BANDS words are copied into buf[wr_sel], full[wr_sel] is set and wr_sel toggles.
  - s_ready for the next cycle reflects the updated flags. It drops the cycle after a capture if the other bank is still full.
- Output side:
  - m_valid = full[rd_sel].
  - m_data = buf[rd_sel][idx], m_index = idx, m_frame = frame_cnt, m_last = (idx == NUM_BANDS-1).
  - All of these hold stable while m_valid & !m_ready.
  - On m_valid & m_ready & !m_last: idx increments.
  - On m_valid & m_ready & m_last:
    - idx returns to 0;
    - full[rd_sel] clears;
    - rd_sel toggles;
    - frame_cnt increments, wrapping at 2^FRAME_CNT_W.
- Latency: a frame captured at edge k gives m_valid = 1 from edge k+1, provided that bank is rd_sel. Minimum frame period is NUM_BANDS cycles with m_ready held high.
- Simultaneous capture and release:
  - If capture targets bank A while the final beat of bank B is accepted in the same cycle, both updates apply.
  - The freed bank B becomes writable at the next edge.
  - A capture can never target the bank being drained, because s_ready is derived from full[wr_sel].
- Both banks full: s_ready = 0. s_valid is ignored and in is not sampled.
- Empty (both banks clear): m_valid = 0. idx holds 0.
- Reset mid-frame: the partially emitted frame and any queued frame are discarded. Output restarts at index 0, frame 0.
- Frame order: frames are emitted strictly in capture order. No frame is dropped or duplicated.
- Ordering with respect to the filter bank: its m_valid/m_ready connect to s_valid/s_ready here. The bank is released exactly on the s_valid & s_ready cycle.

Test Plan:
1. Single frame, in[i] = 16'h0100 + i, m_ready = 1: s_ready = 1 after reset.
   - m_valid rises the cycle after capture.
   - 40 consecutive beats, m_data = 16'h0100..16'h0127.
   - m_last only on beat 39; m_frame = 0.
   - Then m_valid = 0.
2. Backpressure: m_ready held 0 for 10 cycles at idx = 5, then m_ready toggles every cycle.
   - m_data = 16'h0105 is stable throughout the stall.
   - All 40 values arrive in order with no repeats.
3. Fill both banks with m_ready = 0, frame A = 16'hA000 + i, frame B = 16'hB000 + i:
   - s_ready = 0 after the second capture;
   - a third s_valid is ignored for 50 cycles;
   - release m_ready and observe A (m_frame = 0) then B (m_frame = 1);
   - s_ready returns to 1 the cycle after A's last beat.
4. Simultaneous events: offer frame C on the same cycle that A's last beat is accepted while B is queued.
   - C is captured into A's bank.
   - Output order is A, B, C with m_frame 0, 1, 2.
5. Continuous stream, 300 frames, m_ready = 1, new frame offered every 40 cycles:
   - no stalls;
   - m_frame wraps 255 -> 0;
   - every beat matches the scoreboard.
6. Reset asserted at idx = 20 with a second frame queued:
   - m_valid = 0 and s_ready = 0 during reset;
   - after release: s_ready = 1, m_valid = 0;
   - the next frame starts at m_index 0, m_frame 0.

Source files
------------

// File: rtl/mel_frame_serializer_if.sv
// Frame-in / coefficient-out bundle for the mel frame serializer.
// slave is the serializer's view, master is the producer/consumer side.
interface mel_frame_serializer_if #(
  parameter int unsigned NUM_BANDS   = 40,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAME_CNT_W = 8
);
  logic [WIDTH-1:0]       in [NUM_BANDS];
  logic                   s_valid;
  logic                   s_ready;
  logic [WIDTH-1:0]       m_data;
  logic [5:0]             m_index;
  logic [FRAME_CNT_W-1:0] m_frame;
  logic                   m_last;
  logic                   m_valid;
  logic                   m_ready;

  modport slave (
    input  in, s_valid, m_ready,
    output s_ready, m_data, m_index, m_frame, m_last, m_valid
  );

  modport master (
    output in, s_valid, m_ready,
    input  s_ready, m_data, m_index, m_frame, m_last, m_valid
  );
endinterface

// File: rtl/mel_frame_serializer.sv
// Double-buffered parallel-to-serial converter for 40-band mel energy frames.
// Each frame is emitted as NUM_BANDS tagged beats in capture order.
module mel_frame_serializer #(
  parameter int unsigned NUM_BANDS   = 40,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  mel_frame_serializer_if.slave bus
);
  localparam int unsigned      IDX_W    = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  logic [WIDTH-1:0]       bank_q [2][NUM_BANDS];
  logic [1:0]             full_q, full_d;
  logic                   wr_sel_q, wr_sel_d;
  logic                   rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  logic                   s_ready_q;

  logic capture;
  logic beat;
  logic m_valid;
  logic m_last;

  always_comb begin
    m_valid  = full_q[rd_sel_q];
    m_last   = (idx_q == LAST_IDX);
    capture  = bus.s_valid & s_ready_q;
    beat     = m_valid & bus.m_ready;

    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    frame_d  = frame_q;

    // Capture and release always hit different banks, so both may apply.
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (beat) begin
      if (m_last) begin
        idx_d            = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        frame_d          = frame_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      idx_q     <= '0;
      frame_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      // Registered from next-state flags: no m_ready -> s_ready path.
      s_ready_q <= ~full_d[wr_sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      bank_q[wr_sel_q] <= bus.in;
    end
  end

  // Data is masked while empty so outputs read zero out of reset.
  assign bus.m_data  = m_valid ? bank_q[rd_sel_q][idx_q] : '0;
  assign bus.m_index = idx_q;
  assign bus.m_frame = frame_q;
  assign bus.m_last  = m_last;
  assign bus.m_valid = m_valid;
  assign bus.s_ready = s_ready_q;
endmodule

// File: tb/tb_mel_frame_serializer.sv
// Directed bench for mel_frame_serializer: vector table plus hand sequences,
// with a beat scoreboard fed by the frames the bench expects to be captured.
module tb_mel_frame_serializer;
  localparam int unsigned NB = 40;
  localparam int unsigned W  = 16;
  localparam int unsigned FW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mel_frame_serializer_if #(.NUM_BANDS(NB), .WIDTH(W), .FRAME_CNT_W(FW)) bus ();

  mel_frame_serializer #(.NUM_BANDS(NB), .WIDTH(W), .FRAME_CNT_W(FW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        sv;
    logic [15:0] base;
    logic        mr;
    int          reps;
    logic        push;
    logic        e_sr;
    logic        e_mv;
    logic [5:0]  e_idx;
    logic [7:0]  e_fr;
  } vec_t;

  vec_t        tbl [8];
  int          checks = 0;
  int          errors = 0;
  int          beats  = 0;
  int          b0;
  int unsigned rd     = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic sv, input logic [15:0] base);
    bus.s_valid = sv;
    for (int i = 0; i < NB; i++) bus.in[i] = base + 16'(i);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_index", bus.m_index, 0);
    chk("rst_m_frame", bus.m_frame, 0);
    chk("rst_m_last",  bus.m_last,  0);
    chk("rst_m_data",  bus.m_data,  0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Scoreboard: every accepted beat is compared against the queued frame bases.
  task automatic monitor();
    int unsigned b;
    logic [7:0]  ef;
    logic        stall;
    logic [30:0] cur, prev, expv;
    b = 0; ef = '0; stall = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd = exp_q.size(); b = 0; ef = '0; stall = 1'b0;
      end else begin
        cur = {bus.m_data, bus.m_index, bus.m_frame, bus.m_last};
        if (stall) chk("stall_hold", cur, prev);
        if (bus.m_valid && bus.m_ready) begin
          beats++;
          if (rd >= exp_q.size()) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got idx %0d data %0h expected no beat", bus.m_index, bus.m_data);
          end else begin
            expv = {16'(exp_q[rd] + 16'(b)), 6'(b), ef, 1'(b == NB - 1)};
            chk("beat", cur, expv);
            b++;
            if (b == NB) begin
              b = 0; ef++; rd++;
            end
          end
        end
        stall = bus.m_valid & ~bus.m_ready;
        prev  = cur;
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'hA000, 1'b0, 1,  1'b1, 1'b1, 1'b0, 6'd0, 8'd0};
    tbl[1] = '{1'b1, 16'hB000, 1'b0, 1,  1'b1, 1'b1, 1'b1, 6'd0, 8'd0};
    tbl[2] = '{1'b1, 16'hC000, 1'b0, 50, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1,  1'b0, 1'b0, 1'b1, 6'd0, 8'd0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1,  1'b0, 1'b0, 1'b1, 6'd1, 8'd0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1,  1'b0, 1'b0, 1'b1, 6'd2, 8'd0};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1,  1'b0, 1'b0, 1'b1, 6'd2, 8'd0};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1,  1'b0, 1'b0, 1'b1, 6'd3, 8'd0};

    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < NB; i++) bus.in[i] = '0;
    fork
      monitor();
    join_none
    #2;

    // Single frame, streaming
    do_reset();
    chk("t1_s_ready", bus.s_ready, 1);
    chk("t1_idle_valid", bus.m_valid, 0);
    b0 = beats;
    drive_frame(1'b1, 16'h0100);
    exp_q.push_back(16'h0100);
    bus.m_ready = 1'b1;
    cyc();
    bus.s_valid = 1'b0;
    chk("t1_latency_valid", bus.m_valid, 1);
    chk("t1_first_index", bus.m_index, 0);
    chk("t1_first_data", bus.m_data, 16'h0100);
    repeat (40) cyc();
    chk("t1_beats", beats - b0, 40);
    chk("t1_drained", bus.m_valid, 0);

    // Backpressure at idx 5, then toggling ready
    b0 = beats;
    drive_frame(1'b1, 16'h0100);
    exp_q.push_back(16'h0100);
    cyc();
    bus.s_valid = 1'b0;
    repeat (5) cyc();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("t2_stall_index", bus.m_index, 5);
      chk("t2_stall_data", bus.m_data, 16'h0105);
      cyc();
    end
    for (int n = 0; n < 200 && (beats - b0) < 40; n++) begin
      bus.m_ready = (n % 2 == 0);
      cyc();
    end
    bus.m_ready = 1'b1;
    chk("t2_beats", beats - b0, 40);
    chk("t2_drained", bus.m_valid, 0);
    chk("t2_frame_after", bus.m_frame, 2);

    // Both banks full, third frame ignored, then drain
    do_reset();
    b0 = beats;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        drive_frame(tbl[r].sv, tbl[r].base);
        bus.m_ready = tbl[r].mr;
        if (tbl[r].push && k == 0) exp_q.push_back(tbl[r].base);
        @(negedge clk);
        chk("t3_s_ready", bus.s_ready, tbl[r].e_sr);
        chk("t3_m_valid", bus.m_valid, tbl[r].e_mv);
        chk("t3_m_index", bus.m_index, tbl[r].e_idx);
        chk("t3_m_frame", bus.m_frame, tbl[r].e_fr);
        cyc();
      end
    end
    bus.m_ready = 1'b1;
    repeat (35) cyc();
    chk("t3_a_last", bus.m_last, 1);
    chk("t3_a_last_idx", bus.m_index, 39);
    chk("t3_sready_at_last", bus.s_ready, 0);
    cyc();
    chk("t3_sready_after_last", bus.s_ready, 1);
    chk("t3_b_frame", bus.m_frame, 1);
    chk("t3_b_index", bus.m_index, 0);
    chk("t3_b_valid", bus.m_valid, 1);
    repeat (40) cyc();
    chk("t3_beats", beats - b0, 80);
    chk("t3_drained", bus.m_valid, 0);

    // Frame C offered while A's last beat is accepted and B is queued
    do_reset();
    b0 = beats;
    drive_frame(1'b1, 16'hA100);
    exp_q.push_back(16'hA100);
    cyc();
    drive_frame(1'b1, 16'hB100);
    exp_q.push_back(16'hB100);
    cyc();
    chk("t4_full_sready", bus.s_ready, 0);
    drive_frame(1'b1, 16'hC100);
    bus.m_ready = 1'b1;
    repeat (39) cyc();
    chk("t4_a_last", bus.m_last, 1);
    chk("t4_sready_at_last", bus.s_ready, 0);
    cyc();
    chk("t4_sready_after_last", bus.s_ready, 1);
    chk("t4_b_frame", bus.m_frame, 1);
    exp_q.push_back(16'hC100);
    cyc();
    bus.s_valid = 1'b0;
    chk("t4_sready_after_c", bus.s_ready, 0);
    repeat (80) cyc();
    chk("t4_beats", beats - b0, 120);
    chk("t4_drained", bus.m_valid, 0);
    chk("t4_frame_after", bus.m_frame, 3);

    // Continuous stream with frame counter wrap
    do_reset();
    bus.m_ready = 1'b1;
    b0 = beats;
    for (int f = 0; f < 300; f++) begin
      drive_frame(1'b1, 16'(f * 113));
      chk("t5_no_stall", bus.s_ready, 1);
      exp_q.push_back(16'(f * 113));
      cyc();
      bus.s_valid = 1'b0;
      repeat (39) cyc();
    end
    repeat (2) cyc();
    chk("t5_beats", beats - b0, 12000);
    chk("t5_drained", bus.m_valid, 0);
    chk("t5_frame_wrapped", bus.m_frame, 8'(300));

    // Reset mid-frame with a second frame queued
    do_reset();
    bus.m_ready = 1'b1;
    drive_frame(1'b1, 16'hE000);
    exp_q.push_back(16'hE000);
    cyc();
    drive_frame(1'b1, 16'hF000);
    exp_q.push_back(16'hF000);
    cyc();
    bus.s_valid = 1'b0;
    repeat (19) cyc();
    chk("t6_pre_index", bus.m_index, 20);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", bus.m_valid, 0);
    chk("t6_rst_sready", bus.s_ready, 0);
    chk("t6_rst_index", bus.m_index, 0);
    cyc();
    chk("t6_rst_sready_hold", bus.s_ready, 0);
    reset = 1'b0;
    cyc();
    chk("t6_post_sready", bus.s_ready, 1);
    chk("t6_post_valid", bus.m_valid, 0);
    b0 = beats;
    drive_frame(1'b1, 16'h0F00);
    exp_q.push_back(16'h0F00);
    cyc();
    bus.s_valid = 1'b0;
    chk("t6_restart_index", bus.m_index, 0);
    chk("t6_restart_frame", bus.m_frame, 0);
    chk("t6_restart_data", bus.m_data, 16'h0F00);
    repeat (40) cyc();
    chk("t6_beats", beats - b0, 40);
    chk("t6_drained", bus.m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
